// File: rtl/dsi_pkt_scheduler.sv
// dsi_pkt_scheduler: turns VSYNC/HSYNC/DE rises into queued VSS/HSS/line packet requests, sequences LP->HS lane entry/exit and hands one packet at a time to the formatter
module dsi_pkt_scheduler #(
  parameter logic [1:0]  VC      = 2'd0,
  parameter logic [5:0]  DT      = 6'h3E,
  parameter logic [15:0] WC      = 16'h05A0,
  parameter int          T_LPX   = 4,
  parameter int          T_PREP  = 4,
  parameter int          T_ZERO  = 8,
  parameter int          T_TRAIL = 6,
  parameter int          T_EXIT  = 6
) (
  input  logic        PIXCLK,
  input  logic        reset_n,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic        DE,
  input  logic        pkt_done,
  output logic        pkt_start,
  output logic        pkt_long,
  output logic [7:0]  pkt_di,
  output logic [15:0] pkt_wc,
  output logic        hs_en,
  output logic [1:0]  lp_data,
  output logic        busy,
  output logic        ovf
);
  typedef enum logic [2:0] {IDLE, LPX, PREP, ZERO, ISSUE, WAIT, TRAIL, EXIT} state_t;
  state_t st, nxt;
  logic vs_q, hs_q, de_q, vss_p, hss_p, line_p;
  logic rv, rh, rl, any, iss, cv, ch, cl;
  logic [7:0] tmr, ld;
  assign rv = VSYNC & ~vs_q;
  assign rh = HSYNC & ~hs_q;
  assign rl = DE & ~de_q;
  assign any = vss_p | hss_p | line_p;
  assign iss = nxt == ISSUE;
  assign cv = iss & vss_p;
  assign ch = iss & ~vss_p & hss_p;
  assign cl = iss & ~vss_p & ~hss_p & line_p;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = any ? LPX : IDLE;
      LPX:     nxt = tmr == 8'd0 ? PREP : LPX;
      PREP:    nxt = tmr == 8'd0 ? ZERO : PREP;
      ZERO:    nxt = tmr == 8'd0 ? ISSUE : ZERO;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = !pkt_done ? WAIT : any ? ISSUE : TRAIL;
      TRAIL:   nxt = tmr == 8'd0 ? EXIT : TRAIL;
      EXIT:    nxt = tmr == 8'd0 ? IDLE : EXIT;
      default: nxt = IDLE;
    endcase
    ld = nxt == LPX   ? 8'(T_LPX - 1)   :
         nxt == PREP  ? 8'(T_PREP - 1)  :
         nxt == ZERO  ? 8'(T_ZERO - 1)  :
         nxt == TRAIL ? 8'(T_TRAIL - 1) : 8'(T_EXIT - 1);
  end
  always_ff @(posedge PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      {vs_q, hs_q, de_q} <= 3'b000;
      {vss_p, hss_p, line_p} <= 3'b000;
      ovf <= 1'b0;
      st <= IDLE;
      tmr <= 8'd0;
      pkt_start <= 1'b0;
      pkt_long <= 1'b0;
      pkt_di <= 8'd0;
      pkt_wc <= 16'd0;
      hs_en <= 1'b0;
      lp_data <= 2'b11;
      busy <= 1'b0;
    end else begin
      {vs_q, hs_q, de_q} <= {VSYNC, HSYNC, DE};
      vss_p <= rv | (vss_p & ~cv);
      hss_p <= rh | (hss_p & ~ch);
      line_p <= rl | (line_p & ~cl);
      ovf <= ovf | (rv & vss_p & ~cv) | (rh & hss_p & ~ch) | (rl & line_p & ~cl);
      st <= nxt;
      tmr <= nxt != st ? ld : tmr != 8'd0 ? tmr - 8'd1 : tmr;
      pkt_start <= iss;
      if (iss) begin
        pkt_long <= cl;
        pkt_di <= {VC, cv ? 6'h01 : ch ? 6'h21 : DT};
        pkt_wc <= cl ? WC : 16'h0000;
      end
      hs_en <= nxt == ZERO || nxt == ISSUE || nxt == WAIT || nxt == TRAIL;
      lp_data <= nxt == IDLE || nxt == EXIT ? 2'b11 : nxt == LPX ? 2'b01 : 2'b00;
      busy <= nxt != IDLE;
    end
  end
endmodule
